// File: rtl/dispatch_queue_pkg.sv
// Shared types, widths and RV32 opcodes for the fetch-to-dispatch queue.
`ifndef DISPATCH_QUEUE_PKG_MACROS
`define DISPATCH_QUEUE_PKG_MACROS
`define N_WAY 2
`define XLEN 32
`endif

package dispatch_queue_pkg;

    localparam int N_WAY_D = `N_WAY;
    localparam int XLEN_W  = `XLEN;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic              valid;
        logic [31:0]       inst;
        logic [XLEN_W-1:0] PC;
        logic [XLEN_W-1:0] NPC;
        logic [4:0]        src1;
        logic [4:0]        src2;
        logic [4:0]        dest;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and dispatch-side bundle of the dispatch queue.
interface dispatch_queue_if
    import dispatch_queue_pkg::*;
#(
    parameter int N_WAY = N_WAY_D,
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_W
);

    logic [N_WAY-1:0]                if_valid;
    logic [N_WAY-1:0][31:0]          if_inst;
    logic [N_WAY-1:0][XLEN-1:0]      if_pc;
    logic [N_WAY-1:0][XLEN-1:0]      if_npc;
    logic                            if_ready;
    DISPATCH_PACKET_R10K [N_WAY-1:0] dispatch_packet;
    logic [N_WAY-1:0]                branch_inst;
    logic [N_WAY-1:0]                dispatched;
    logic                            branch_haz;
    logic [$clog2(DEPTH):0]          q_count;

    modport master (
        output if_valid,
        output if_inst,
        output if_pc,
        output if_npc,
        input  if_ready,
        input  dispatch_packet,
        input  branch_inst,
        output dispatched,
        output branch_haz,
        input  q_count
    );

    modport slave (
        input  if_valid,
        input  if_inst,
        input  if_pc,
        input  if_npc,
        output if_ready,
        output dispatch_packet,
        output branch_inst,
        input  dispatched,
        input  branch_haz,
        output q_count
    );

endinterface

// File: rtl/dq_decode.sv
// Per-lane register-field extraction and branch detection.
module dq_decode
    import dispatch_queue_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  dest,
    output logic        is_branch
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    always_comb begin
        src1      = inst[19:15];
        src2      = inst[24:20];
        dest      = inst[11:7];
        is_branch = 1'b0;
        unique case (opcode)
            OP_BRANCH: begin
                dest      = 5'd0;
                is_branch = 1'b1;
            end
            OP_STORE: begin
                dest = 5'd0;
            end
            OP_IMM, OP_LOAD: begin
                src2 = 5'd0;
            end
            OP_JALR: begin
                src2      = 5'd0;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                src1      = 5'd0;
                src2      = 5'd0;
                is_branch = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                src1 = 5'd0;
                src2 = 5'd0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order circular instruction buffer between fetch and rename/dispatch.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int N_WAY = N_WAY_D,
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_W
) (
    input logic             clock,
    input logic             reset,
    dispatch_queue_if.slave dq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - N_WAY);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] npc_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          ready;
    logic [CW-1:0] n_in;
    logic [CW-1:0] n_out;

    logic [N_WAY-1:0] lane_valid;
    logic [PW-1:0]    lane_idx  [N_WAY];
    logic [31:0]      lane_inst [N_WAY];
    logic [4:0]       lane_src1 [N_WAY];
    logic [4:0]       lane_src2 [N_WAY];
    logic [4:0]       lane_dest [N_WAY];
    logic [N_WAY-1:0] lane_br;

    // Free space is judged on the registered count only.
    assign ready       = count <= READY_MAX;
    assign dq.if_ready = ready;
    assign dq.q_count  = count;

    always_comb begin
        logic run;
        n_in = '0;
        run  = ready;
        for (int j = 0; j < N_WAY; j++) begin
            run  = run & dq.if_valid[j];
            n_in = n_in + CW'(run);
        end
    end

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            lane_idx[i]   = head + PW'(i);
            lane_valid[i] = CW'(i) < count;
            lane_inst[i]  = inst_mem[lane_idx[i]];
        end
    end

    // Retire stops at the first lane not taken so order is preserved.
    always_comb begin
        logic run;
        n_out = '0;
        run   = 1'b1;
        for (int i = 0; i < N_WAY; i++) begin
            run   = run & dq.dispatched[i] & lane_valid[i];
            n_out = n_out + CW'(run);
        end
    end

    for (genvar i = 0; i < N_WAY; i++) begin : g_lane
        dq_decode u_dec (
            .inst      (lane_inst[i]),
            .src1      (lane_src1[i]),
            .src2      (lane_src2[i]),
            .dest      (lane_dest[i]),
            .is_branch (lane_br[i])
        );
    end

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            dq.dispatch_packet[i] = '0;
            if (lane_valid[i]) begin
                dq.dispatch_packet[i].valid = 1'b1;
                dq.dispatch_packet[i].inst  = lane_inst[i];
                dq.dispatch_packet[i].PC    = pc_mem[lane_idx[i]];
                dq.dispatch_packet[i].NPC   = npc_mem[lane_idx[i]];
                dq.dispatch_packet[i].src1  = lane_src1[i];
                dq.dispatch_packet[i].src2  = lane_src2[i];
                dq.dispatch_packet[i].dest  = lane_dest[i];
            end
        end
    end

    assign dq.branch_inst = lane_valid & lane_br;

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (dq.branch_haz) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + n_out[PW-1:0];
            tail  <= tail + n_in[PW-1:0];
            count <= count + n_in - n_out;
        end
    end

    // Payload needs no reset; validity comes from count alone.
    always_ff @(posedge clock) begin
        for (int j = 0; j < N_WAY; j++) begin
            if (CW'(j) < n_in) begin
                inst_mem[tail + PW'(j)] <= dq.if_inst[j];
                pc_mem[tail + PW'(j)]   <= dq.if_pc[j];
                npc_mem[tail + PW'(j)]  <= dq.if_npc[j];
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset) count <= FULL
    );

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed scoreboard bench for the dispatch queue.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int NW    = 2;
    localparam int DEPTH = 8;
    localparam int XL    = 32;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    logic [31:0] next_pc = 32'h0;
    logic [31:0] lane_inst [NW];
    logic [31:0] exp_word;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_BEQ   = 32'h00520063;
    localparam logic [31:0] I_LW    = 32'h0083A303;
    localparam logic [31:0] I_SW    = 32'h0084A223;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_LUI   = 32'h12345537;
    localparam logic [31:0] I_ADDI  = 32'h00560593;
    localparam logic [31:0] I_AUIPC = 32'h00001697;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_SUB   = 32'h41078733;

    dispatch_queue_if #(.N_WAY(NW), .DEPTH(DEPTH), .XLEN(XL)) dq_if ();

    dispatch_queue #(.N_WAY(NW), .DEPTH(DEPTH), .XLEN(XL)) u_dut (
        .clock (clock),
        .reset (reset),
        .dq    (dq_if)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {is_branch, src1, src2, dest} from the RV32 field layout.
    function automatic logic [15:0] ref_dec(logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [4:0] s1 = w[19:15];
        logic [4:0] s2 = w[24:20];
        logic [4:0] d  = w[11:7];
        logic       br;
        if (op == 7'b1100011 || op == 7'b0100011) d = 5'd0;
        if (op inside {7'b0010011, 7'b0000011, 7'b1101111,
                       7'b1100111, 7'b0110111, 7'b0010111}) s2 = 5'd0;
        if (op inside {7'b1101111, 7'b0110111, 7'b0010111}) s1 = 5'd0;
        br = op inside {7'b1100011, 7'b1101111, 7'b1100111};
        return {br, s1, s2, d};
    endfunction

    task automatic check_state(string tag);
        logic [15:0] d;
        chk({tag, ".count"}, dq_if.q_count, sb.size());
        chk({tag, ".ready"}, dq_if.if_ready, (DEPTH - sb.size()) >= NW);
        for (int i = 0; i < NW; i++) begin
            if (i < sb.size()) begin
                d = ref_dec(sb[i].inst);
                chk($sformatf("%s.l%0d.valid", tag, i),
                    dq_if.dispatch_packet[i].valid, 1'b1);
                chk($sformatf("%s.l%0d.inst", tag, i),
                    dq_if.dispatch_packet[i].inst, sb[i].inst);
                chk($sformatf("%s.l%0d.pc", tag, i),
                    dq_if.dispatch_packet[i].PC, sb[i].pc);
                chk($sformatf("%s.l%0d.npc", tag, i),
                    dq_if.dispatch_packet[i].NPC, sb[i].pc + 32'd4);
                chk($sformatf("%s.l%0d.regs", tag, i),
                    {dq_if.dispatch_packet[i].src1,
                     dq_if.dispatch_packet[i].src2,
                     dq_if.dispatch_packet[i].dest}, d[14:0]);
                chk($sformatf("%s.l%0d.br", tag, i),
                    dq_if.branch_inst[i], d[15]);
            end else begin
                chk($sformatf("%s.l%0d.pkt", tag, i),
                    dq_if.dispatch_packet[i], '0);
                chk($sformatf("%s.l%0d.br", tag, i),
                    dq_if.branch_inst[i], 1'b0);
            end
        end
    endtask

    task automatic do_cycle(logic [1:0] v, logic [1:0] disp,
                            logic haz, string tag);
        int n_in = 0;
        int n_out = 0;
        int sz = sb.size();
        bit run;
        for (int j = 0; j < NW; j++) begin
            dq_if.if_inst[j] = lane_inst[j];
            dq_if.if_pc[j]   = next_pc + 32'(4 * j);
            dq_if.if_npc[j]  = next_pc + 32'(4 * j + 4);
        end
        dq_if.if_valid   = v;
        dq_if.dispatched = disp;
        dq_if.branch_haz = haz;
        run = (DEPTH - sz) >= NW;
        for (int j = 0; j < NW; j++) begin
            run  = run & v[j];
            n_in = n_in + int'(run);
        end
        run = 1'b1;
        for (int i = 0; i < NW; i++) begin
            run   = run & disp[i] & (i < sz);
            n_out = n_out + int'(run);
        end
        for (int i = 0; i < n_out; i++) begin
            chk($sformatf("%s.retire%0d", tag, i),
                {dq_if.dispatch_packet[i].inst, dq_if.dispatch_packet[i].PC},
                {sb[i].inst, sb[i].pc});
        end
        @(posedge clock);
        #1;
        if (haz) begin
            sb.delete();
        end else begin
            repeat (n_out) void'(sb.pop_front());
            for (int j = 0; j < n_in; j++)
                sb.push_back('{inst: lane_inst[j], pc: next_pc + 32'(4 * j)});
            next_pc = next_pc + 32'(4 * n_in);
        end
        dq_if.if_valid   = '0;
        dq_if.dispatched = '0;
        dq_if.branch_haz = 1'b0;
        check_state(tag);
    endtask

    initial begin
        dq_if.if_valid   = '0;
        dq_if.if_inst    = '0;
        dq_if.if_pc      = '0;
        dq_if.if_npc     = '0;
        dq_if.dispatched = '0;
        dq_if.branch_haz = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_state("reset");
        repeat (4) do_cycle(2'b00, 2'b00, 1'b0, "idle");
        chk("idle.valid", {dq_if.dispatch_packet[1].valid,
                           dq_if.dispatch_packet[0].valid}, 2'b00);
        chk("idle.brinst", dq_if.branch_inst, 2'b00);

        lane_inst[0] = I_ADD;
        lane_inst[1] = I_BEQ;
        do_cycle(2'b11, 2'b00, 1'b0, "push2");
        chk("push2.count", dq_if.q_count, 2);
        chk("push2.l0", {dq_if.dispatch_packet[0].src1,
                         dq_if.dispatch_packet[0].src2,
                         dq_if.dispatch_packet[0].dest}, {5'd1, 5'd2, 5'd3});
        chk("push2.l1", {dq_if.dispatch_packet[1].src1,
                         dq_if.dispatch_packet[1].src2,
                         dq_if.dispatch_packet[1].dest}, {5'd4, 5'd5, 5'd0});
        chk("push2.brinst", dq_if.branch_inst, 2'b10);

        lane_inst[0] = I_LW;    lane_inst[1] = I_SW;
        do_cycle(2'b11, 2'b00, 1'b0, "fill4");
        lane_inst[0] = I_JAL;   lane_inst[1] = I_LUI;
        do_cycle(2'b11, 2'b00, 1'b0, "fill6");
        lane_inst[0] = I_ADDI;  lane_inst[1] = I_AUIPC;
        do_cycle(2'b11, 2'b00, 1'b0, "fill8");
        chk("full.count", dq_if.q_count, 8);
        chk("full.ready", dq_if.if_ready, 1'b0);
        lane_inst[0] = I_JALR;  lane_inst[1] = I_SUB;
        do_cycle(2'b11, 2'b00, 1'b0, "full_push");
        chk("full_push.count", dq_if.q_count, 8);
        do_cycle(2'b11, 2'b11, 1'b0, "full_pushpop");
        chk("full_pushpop.count", dq_if.q_count, 6);

        do_cycle(2'b00, 2'b11, 1'b0, "pop2");
        do_cycle(2'b00, 2'b01, 1'b0, "pop1");
        chk("pop1.count", dq_if.q_count, 3);
        exp_word = sb[1].inst;
        do_cycle(2'b00, 2'b10, 1'b0, "hole");
        chk("hole.count", dq_if.q_count, 3);
        do_cycle(2'b00, 2'b01, 1'b0, "after_hole");
        chk("after_hole.count", dq_if.q_count, 2);
        chk("after_hole.l0", dq_if.dispatch_packet[0].inst, exp_word);

        do_cycle(2'b00, 2'b01, 1'b0, "to_head7");
        do_cycle(2'b11, 2'b00, 1'b0, "wrap");
        chk("wrap.l0inst", dq_if.dispatch_packet[0].inst, I_AUIPC);
        chk("wrap.l1inst", dq_if.dispatch_packet[1].inst, I_JALR);
        chk("wrap.l0pc", dq_if.dispatch_packet[0].PC, 32'h1C);
        chk("wrap.l1pc", dq_if.dispatch_packet[1].PC, 32'h20);

        lane_inst[0] = I_ADD;   lane_inst[1] = I_BEQ;
        do_cycle(2'b11, 2'b00, 1'b0, "pre_flush");
        chk("pre_flush.count", dq_if.q_count, 5);
        do_cycle(2'b11, 2'b11, 1'b1, "flush");
        chk("flush.count", dq_if.q_count, 0);
        chk("flush.ready", dq_if.if_ready, 1'b1);
        chk("flush.valid", {dq_if.dispatch_packet[1].valid,
                            dq_if.dispatch_packet[0].valid}, 2'b00);

        lane_inst[0] = I_LUI;   lane_inst[1] = I_SW;
        do_cycle(2'b11, 2'b00, 1'b0, "post_flush");
        lane_inst[0] = I_JAL;   lane_inst[1] = I_ADDI;
        do_cycle(2'b10, 2'b00, 1'b0, "nonprefix");
        chk("nonprefix.count", dq_if.q_count, 2);
        do_cycle(2'b01, 2'b11, 1'b0, "drain_push1");
        do_cycle(2'b00, 2'b11, 1'b0, "drain");
        chk("drain.count", dq_if.q_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order instruction buffer between fetch and the R10K rename/dispatch top.
- Accepts up to N_WAY fetched instructions per cycle and holds them in a circular FIFO.
- Presents the oldest N_WAY entries as decoded dispatch packets.
- Retires entries according to the per-way dispatched mask returned by the ROB/RS side. Flushes completely on branch_haz.

Parameters:
- N_WAY, 2, superscalar width; lanes per cycle on both the fetch and dispatch sides.
- DEPTH, 8, FIFO entries; power of two, DEPTH >= 2*N_WAY.
- XLEN, 32, PC width.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- if_valid  input  N_WAY  per-lane fetch valid; must be a prefix (lane i valid implies lanes 0..i-1 valid).
- if_inst  input  N_WAY x 32  fetched instruction words.
- if_pc  input  N_WAY x XLEN  instruction PCs.
- if_npc  input  N_WAY x XLEN  next PCs.
- if_ready  output  1  queue can accept a full N_WAY group this cycle.
- dispatch_packet  output  N_WAY x DISPATCH_PACKET_R10K  fields: valid, inst, PC, NPC, src1, src2, dest.
- branch_inst  output  N_WAY  lane holds a conditional branch or jump.
- dispatched  input  N_WAY  per-lane acceptance by ROB/RS this cycle.
- branch_haz  input  1  mispredict flush.
- q_count  output  $clog2(DEPTH)+1  occupancy (debug).

Behaviour:
- Storage:
  - Entry array of {inst, PC, NPC}, DEPTH deep.
  - Pointers head and tail, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy register count.
- Reset (synchronous): head=0, tail=0, count=0. Consequently all dispatch_packet[i].valid=0, branch_inst=0, if_ready=1, q_count=0. Entry payloads are don't-care.
- if_ready = (DEPTH - count) >= N_WAY. Computed from the registered count only; same-cycle pops are not credited.
- Enqueue:
  - n_in = number of leading ones in if_valid, taken only when if_ready=1; otherwise 0.
  - Lane j is written at tail+j. tail += n_in.
  - A non-prefix if_valid (e.g. 2'b10) enqueues only the leading ones (0 for 2'b10).
- Dispatch output (combinational from registered state, zero-latency):
  - Lane i shows entry head+i. valid = (i < count).
  - src1 = inst[19:15], src2 = inst[24:20], dest = inst[11:7].
  - dest forced to 0 for opcode BRANCH (1100011) and STORE (0100011).
  - src2 forced to 0 for I-type, LOAD, JAL, JALR, LUI and AUIPC. src1 forced to 0 for JAL, LUI and AUIPC.
  - Invalid lanes drive all fields 0.
  - branch_inst[i] = valid & opcode in {1100011, 1101111, 1100111}.
- Dequeue:
  - n_out = leading ones of (dispatched & valid_mask). head += n_out.
  - A hole in dispatched (e.g. 2'b10) retires nothing from the hole onward; order is preserved.
- count_next = count + n_in - n_out. Simultaneous push and pop are legal at every occupancy, including full and empty.
- Flush: branch_haz=1 sets head=0, tail=0, count=0 in the next cycle. Same-cycle enqueue and dequeue are discarded. Flush has priority over both; reset has priority over flush.
- Wrap-around: entries spanning index DEPTH-1 to index 0 are presented contiguously to lanes 0..N_WAY-1.
- Invariant (checked by assertion): count <= DEPTH; never overflows because of the if_ready rule.

Decomposition:
- Shared package holds:
  - DISPATCH_PACKET_R10K typedef (existing).
  - Opcode constants: OP_BRANCH, OP_STORE, OP_LOAD, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - `N_WAY and `XLEN macros (existing).
- One natural sub-module: dq_decode. It is combinational, one instance per lane, and maps inst to src1, src2, dest and is_branch.
- FIFO control stays in dispatch_queue.

Test Plan:
- Reset, then 4 cycles idle -> q_count=0, if_ready=1, dispatch_packet valid=2'b00, branch_inst=2'b00.
- Push 2 instrs (add x3,x1,x2 at PC 0x0; beq x4,x5 at PC 0x4) with dispatched=0 -> next cycle count=2. Lane0: src1=1, src2=2, dest=3. Lane1: src1=4, src2=5, dest=0, branch_inst=2'b10.
- Fill to 8 entries -> if_ready=0 and a further push is ignored, count stays 8. Then dispatched=2'b11 with a simultaneous push -> count=6, not 8, because ready was low that cycle.
- dispatched=2'b10 with 3 entries queued -> head unchanged, count=3. Then dispatched=2'b01 -> count=2 and lane0 shows the former lane1 instruction.
- Wrap: advance head to 7 and enqueue 2 -> lanes show entries 7 and 0 in order, with PCs consecutive.
- branch_haz=1 together with push 2'b11 and dispatched=2'b11 at count=5 -> next cycle count=0, valid=0, head=tail=0, if_ready=1.
